// File: rtl/log_block_buffer_pkg.sv
// Shared types and defaults for the block-mode logging buffer (log_block_buffer).
package log_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] HDR_MAGIC      = 4'hA;
  localparam int         LOG_W_OUT      = 16;
  localparam int         LOG_DEPTH_LOG2 = 10;

endpackage

// File: rtl/log_block_buffer_ram.sv
// Simple dual-port RAM (one write port, one read port) with a registered read,
// used as block storage by log_block_buffer.
module log_buf_ram #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_rd_data;

  // NOTE: the array itself is never reset so it still maps onto block RAM;
  // only the output register is cleared.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/log_block_buffer.sv
// Block-mode log capture: masked, decimated channels fill a 2^DEPTH_LOG2 block that
// the pipe side drains with rd_in. Optional block header: LOG_BLOCK_HEADER_EN.
module log_block_buffer
  import log_pkg::*;
#(
  parameter int N_LOG      = 8,
  parameter int W_LCHAN    = 5,
  parameter int W_LDATA    = 18,
  parameter int W_OUT      = LOG_W_OUT,
  parameter int DEPTH_LOG2 = LOG_DEPTH_LOG2,
  parameter int W_DEC      = 16,
  parameter int W_DROP     = 16
) (
  input  logic               pid_clk_in,
  input  logic               rst_in,
  input  logic               log_dv_in,
  input  logic [W_LCHAN-1:0] log_chan_in,
  input  logic [W_LDATA-1:0] log_data_in,
  input  logic [N_LOG-1:0]   chan_mask_in,
  input  logic [W_DEC-1:0]   dec_in,
  input  logic               cont_in,
  input  logic               arm_in,
  input  logic               abort_in,
  input  logic               rd_in,
  output logic [W_OUT-1:0]   data_out,
  output logic               block_rdy_out,
  output logic               busy_out,
  output logic [W_DROP-1:0]  drop_cnt_out
);

  localparam int W_IDX = (N_LOG > 1) ? $clog2(N_LOG) : 1;
  localparam logic [DEPTH_LOG2-1:0] LAST = '1;
`ifdef LOG_BLOCK_HEADER_EN
  localparam logic [DEPTH_LOG2-1:0] FIRST_WR = DEPTH_LOG2'(1);
`else
  localparam logic [DEPTH_LOG2-1:0] FIRST_WR = '0;
`endif

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [N_LOG-1:0]      r_mask;
  logic [W_DEC-1:0]      r_dec;
  logic                  r_cont;
  logic [W_DEC-1:0]      r_dec_cnt [N_LOG];
  logic [W_DROP-1:0]     r_drop_cnt;

  logic [W_IDX-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_hit;
  logic                  w_pass;
  logic [W_DEC-1:0]      w_reload;
  logic                  w_wr_en;
  logic                  w_last_wr;
  logic                  w_last_rd;
  logic                  w_rd_en;
  logic [DEPTH_LOG2-1:0] w_rd_addr;
  logic [W_OUT-1:0]      w_ram_q;
  logic                  w_unused;

  assign w_idx      = log_chan_in[W_IDX-1:0];
  assign w_in_range = {1'b0, log_chan_in} < (W_LCHAN + 1)'(N_LOG);
  assign w_hit      = log_dv_in && w_in_range && r_mask[w_idx];
  assign w_pass     = w_hit && (r_dec_cnt[w_idx] == '0);
  assign w_reload   = (r_dec <= W_DEC'(1)) ? '0 : r_dec - W_DEC'(1);
  assign w_wr_en    = (r_state == ST_FILL) && w_pass;
  assign w_last_wr  = w_wr_en && (r_wr_ptr == LAST);
  assign w_last_rd  = (r_state == ST_DRAIN) && rd_in && (r_rd_ptr == LAST);
  assign w_unused   = ^log_data_in[W_LDATA-W_OUT-1:0];

  // READY keeps re-reading word 0; once the last word is consumed no further
  // read is issued, so data_out holds that word afterwards.
  assign w_rd_en   = (r_state == ST_READY) ||
                     ((r_state == ST_DRAIN) && rd_in && (r_rd_ptr != LAST));
  assign w_rd_addr = rd_in ? r_rd_ptr + DEPTH_LOG2'(1) : r_rd_ptr;

  log_buf_ram #(.W(W_OUT), .AW(DEPTH_LOG2)) u_ram (
    .i_clk     (pid_clk_in),
    .i_rst     (rst_in),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (log_data_in[W_LDATA-1 -: W_OUT]),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge pid_clk_in) begin
    if (rst_in) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mask     <= '0;
      r_dec      <= '0;
      r_cont     <= 1'b0;
      r_drop_cnt <= '0;
      for (int i = 0; i < N_LOG; i++) r_dec_cnt[i] <= '0;
    end else begin
      // Decimation runs in every active state so drops obey the same cadence.
      if (r_state != ST_IDLE && w_hit)
        r_dec_cnt[w_idx] <= (r_dec_cnt[w_idx] == '0) ? w_reload
                                                     : r_dec_cnt[w_idx] - W_DEC'(1);

      if ((r_state == ST_READY || r_state == ST_DRAIN) && w_pass && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + W_DROP'(1);

      if (abort_in) begin
        r_state  <= ST_IDLE;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        case (r_state)
          ST_IDLE: if (arm_in) begin
            r_mask     <= chan_mask_in;
            r_dec      <= dec_in;
            r_cont     <= cont_in;
            r_drop_cnt <= '0;
            r_wr_ptr   <= FIRST_WR;
            for (int i = 0; i < N_LOG; i++) r_dec_cnt[i] <= '0;
            r_state    <= ST_FILL;
          end
          ST_FILL: if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_last_wr) r_state <= ST_READY;
          end
          ST_READY: if (rd_in) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_state  <= ST_DRAIN;
          end
          ST_DRAIN: if (rd_in) begin
            r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            if (w_last_rd) begin
              r_wr_ptr <= FIRST_WR;
              r_state  <= r_cont ? ST_FILL : ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef LOG_BLOCK_HEADER_EN
  // Word 0 lives in a register so the header never competes with a sample
  // for the single RAM write port.
  logic [W_OUT-5:0] r_seq;
  logic [W_OUT-1:0] r_hdr_word;
  logic             r_rd_hdr;

  always_ff @(posedge pid_clk_in) begin
    if (rst_in) begin
      r_seq      <= '0;
      r_hdr_word <= '0;
      r_rd_hdr   <= 1'b0;
    end else begin
      if (w_rd_en) r_rd_hdr <= (w_rd_addr == '0);
      if (!abort_in) begin
        if (r_state == ST_IDLE && arm_in) begin
          r_seq      <= '0;
          r_hdr_word <= {HDR_MAGIC, {(W_OUT-4){1'b0}}};
        end
        if (w_last_wr)           r_seq      <= r_seq + 1'b1;
        if (w_last_rd && r_cont) r_hdr_word <= {HDR_MAGIC, r_seq};
      end
    end
  end

  assign data_out = r_rd_hdr ? r_hdr_word : w_ram_q;
`else
  assign data_out = w_ram_q;
`endif

  assign block_rdy_out = (r_state == ST_READY) || (r_state == ST_DRAIN);
  assign busy_out      = (r_state != ST_IDLE);
  assign drop_cnt_out  = r_drop_cnt;

endmodule

// File: tb/tb_log_block_buffer.sv
// Directed bench for log_block_buffer (DEPTH_LOG2=4); a second instance with
// W_DROP=3 shares the stimulus to exercise drop-counter saturation.
module tb_log_block_buffer;

`ifdef LOG_BLOCK_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BLK    = 16;
  localparam int N_SAMP = BLK - HDR;

  logic        clk = 1'b0;
  logic        rst, dv, cont, arm, abort, rd;
  logic [4:0]  chan;
  logic [17:0] ldata;
  logic [7:0]  mask;
  logic [15:0] dec;

  logic [15:0] data_out;
  logic        rdy, busy;
  logic [15:0] drop;
  logic [15:0] sat_data_unused;
  logic        sat_rdy_unused, sat_busy_unused;
  logic [2:0]  sat_drop;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  log_block_buffer #(.DEPTH_LOG2(4)) u_dut (
    .pid_clk_in (clk), .rst_in (rst), .log_dv_in (dv), .log_chan_in (chan),
    .log_data_in (ldata), .chan_mask_in (mask), .dec_in (dec), .cont_in (cont),
    .arm_in (arm), .abort_in (abort), .rd_in (rd), .data_out (data_out),
    .block_rdy_out (rdy), .busy_out (busy), .drop_cnt_out (drop)
  );

  log_block_buffer #(.DEPTH_LOG2(4), .W_DROP(3)) u_dut_sat (
    .pid_clk_in (clk), .rst_in (rst), .log_dv_in (dv), .log_chan_in (chan),
    .log_data_in (ldata), .chan_mask_in (mask), .dec_in (dec), .cont_in (cont),
    .arm_in (arm), .abort_in (abort), .rd_in (rd), .data_out (sat_data_unused),
    .block_rdy_out (sat_rdy_unused), .busy_out (sat_busy_unused), .drop_cnt_out (sat_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [7:0] m, input logic [15:0] d, input logic c);
    mask = m; dec = d; cont = c; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic sample(input logic [4:0] ch, input logic [15:0] w);
    dv = 1'b1; chan = ch; ldata = {w, 2'b01};
    tick();
    dv = 1'b0;
  endtask

  task automatic push_hdr(input logic [15:0] seq);
    if (HDR == 1) exp_q.push_back(16'hA000 | seq);
  endtask

  // Fills a block on channel 0 with consecutive words starting at base.
  task automatic fill_ch0(input logic [15:0] base);
    for (int i = 0; i < N_SAMP; i++) begin
      exp_q.push_back(base + 16'(i));
      sample(5'd0, base + 16'(i));
    end
  endtask

  task automatic read_words(input int n, input string tag);
    logic [15:0] e;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, i), data_out, e);
      rd = 1'b1;
      tick();
      rd = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pushed;
    rst = 1'b1; dv = 0; cont = 0; arm = 0; abort = 0; rd = 0;
    chan = '0; ldata = '0; mask = '0; dec = '0;
    tick();
    rst = 1'b0;
    check("rst_data", data_out, 0);
    check("rst_rdy", rdy, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);

    // 1: single channel, one-shot
    do_arm(8'b0000_0001, 16'd0, 1'b0);
    check("t1_busy", busy, 1);
    push_hdr(0);
    fill_ch0(16'd0);
    check("t1_rdy", rdy, 1);
    tick();
    read_words(BLK, "t1");
    check("t1_idle_busy", busy, 0);
    check("t1_idle_rdy", rdy, 0);

    // 2: two channels decimated by 3, with masked-off and out-of-range noise
    do_arm(8'b0000_0110, 16'd3, 1'b0);
    push_hdr(0);
    pushed = 0;
    for (int k = 0; k < 40 && pushed < N_SAMP; k++) begin
      sample(5'd0, 16'hEEEE);
      sample(5'd20, 16'hDDDD);
      sample(5'd1, 16'h1000 + 16'(k));
      if (k % 3 == 0) begin exp_q.push_back(16'h1000 + 16'(k)); pushed++; end
      if (pushed < N_SAMP) begin
        sample(5'd2, 16'h2000 + 16'(k));
        if (k % 3 == 0) begin exp_q.push_back(16'h2000 + 16'(k)); pushed++; end
      end
    end
    check("t2_rdy", rdy, 1);
    check("t2_drop", drop, 0);
    tick();
    read_words(BLK, "t2");
    check("t2_idle", busy, 0);

    // 3: drops while the block is full, plus saturation on the narrow counter
    do_arm(8'b0000_0001, 16'd0, 1'b0);
    push_hdr(0);
    fill_ch0(16'h0100);
    for (int i = 0; i < 5; i++) sample(5'd0, 16'hBAD0);
    sample(5'd3, 16'hBAD1);
    check("t3_drop5", drop, 5);
    check("t3_sat5", sat_drop, 5);
    for (int i = 0; i < 5; i++) sample(5'd0, 16'hBAD2);
    check("t3_drop10", drop, 10);
    check("t3_sat7", sat_drop, 7);
    read_words(1, "t3");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_rdy", rdy, 0);
    check("t3_abort_drop", drop, 10);
    exp_q.delete();

    // 4: reset in the middle of a fill
    do_arm(8'b0000_0001, 16'd0, 1'b0);
    for (int i = 0; i < 7; i++) sample(5'd0, 16'h7700 + 16'(i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_data", data_out, 0);
    check("t4_rdy", rdy, 0);
    check("t4_busy", busy, 0);
    check("t4_drop", drop, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("t4_rd_data", data_out, 0);

    // 5: continuous mode, two back-to-back blocks
    do_arm(8'b0000_0001, 16'd0, 1'b1);
    push_hdr(0);
    fill_ch0(16'h0300);
    tick();
    read_words(BLK, "t5b0");
    check("t5_refill_busy", busy, 1);
    check("t5_refill_rdy", rdy, 0);
    push_hdr(1);
    fill_ch0(16'h0400);
    check("t5_rdy", rdy, 1);
    tick();
    read_words(BLK, "t5b1");
    check("t5_cont_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // 6: abort mid-drain, then a fresh block reads from word 0
    do_arm(8'b0000_0001, 16'd0, 1'b0);
    push_hdr(0);
    fill_ch0(16'h0500);
    tick();
    read_words(5, "t6a");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_rdy", rdy, 0);
    check("t6_abort_busy", busy, 0);
    exp_q.delete();
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    check("t6_abort_wins", busy, 0);
    do_arm(8'b0000_0001, 16'd0, 1'b0);
    push_hdr(0);
    fill_ch0(16'h0600);
    tick();
    read_words(BLK, "t6b");
    check("t6_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/log_block_buffer.md
Name: log_block_buffer

Overview:
- Single-clock block-mode logging buffer; next generation of the pipe-out logging path.
- Captures samples from the log bus for any subset of N_LOG channels (mask, not a single pipe channel), with per-channel decimation.
- Assembles fixed-length blocks of 2^DEPTH_LOG2 words and exposes them to the pipe-out read side through a read strobe.
- Sits between the PID log bus and the pipe-out FIFO/endpoint; supports one-shot and continuous capture, and counts dropped samples.

Parameters:
- N_LOG, 8, number of log channels.
- W_LCHAN, 5, log channel index width.
- W_LDATA, 18, log sample width.
- W_OUT, 16, output word width; stored word = log_data_in[W_LDATA-1 -: W_OUT].
- DEPTH_LOG2, 10, block length = 2^DEPTH_LOG2 words.
- W_DEC, 16, decimation factor width.
- W_DROP, 16, drop counter width.

Ports:
- pid_clk_in  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- log_dv_in  in  1  log sample valid.
- log_chan_in  in  W_LCHAN  channel of the current sample.
- log_data_in  in  W_LDATA  sample data.
- chan_mask_in  in  N_LOG  channel enable mask, sampled at arm.
- dec_in  in  W_DEC  decimation factor, sampled at arm; 0 and 1 both mean "keep every sample".
- cont_in  in  1  continuous mode, sampled at arm.
- arm_in  in  1  single-cycle pulse that starts capture.
- abort_in  in  1  single-cycle pulse that returns the block to IDLE.
- rd_in  in  1  read strobe from the pipe side.
- data_out  out  W_OUT  current read word (registered).
- block_rdy_out  out  1  full block is available to read.
- busy_out  out  1  state != IDLE.
- drop_cnt_out  out  W_DROP  saturating count of dropped samples.

Behaviour:
- Reset (synchronous, rst_in=1): state IDLE, wr/rd pointers 0, all decimation counters 0, data_out=0, block_rdy_out=0, busy_out=0, drop_cnt_out=0. Reset overrides every other input, including mid-fill and mid-drain.
- States:
  - IDLE: arm_in latches mask/dec/cont, clears all decimation counters, clears drop_cnt, sets wr_ptr=0 -> FILL (next cycle).
  - FILL: accepts a sample when log_dv_in=1, chan_mask[log_chan_in]=1, log_chan_in<N_LOG, and that channel's decimation counter=0. The sample is written to mem[wr_ptr] and wr_ptr++. The channel counter reloads to dec-1 (0 if dec<=1); otherwise the counter decrements on each valid sample of that channel. The write of the last word (wr_ptr=2^DEPTH_LOG2-1) -> READY, and wr_ptr wraps to 0.
  - READY: block_rdy_out=1. The memory read of word 0 is issued on entry, so data_out=word 0 one cycle after entering READY. The first rd_in -> DRAIN.
  - DRAIN: block_rdy_out stays 1. Each rd_in advances rd_ptr; data_out shows the next word on the following cycle (1-cycle latency). The rd_in that consumes the last word -> FILL if cont=1 (decimation counters keep running), else IDLE. rd_ptr wraps to 0 and block_rdy_out deasserts the next cycle.
- Drops: in READY/DRAIN, a sample that passes mask and decimation is not stored; drop_cnt increments and saturates at all-ones.
- rd_in in IDLE/FILL: ignored; data_out holds.
- arm_in when not IDLE: ignored.
- abort_in in any state: -> IDLE next cycle; block_rdy_out=0; pointers 0; drop_cnt preserved.
- Simultaneous abort_in and arm_in: abort_in wins.
- Simultaneous last write and rd_in: impossible, since reads are ignored in FILL.
- Channels with index >= N_LOG: always ignored, never counted as drops.
- Memory: single-port-per-side simple dual-port, 2^DEPTH_LOG2 x W_OUT, registered read; inferable as block RAM.

Optional Feature:
- Macro: LOG_BLOCK_HEADER_EN.
- Enabled:
  - Word 0 of each block is a header {4'hA, seq[W_OUT-5:0]}.
  - Samples fill words 1..2^DEPTH_LOG2-1.
  - seq starts at 0 on arm and increments per completed block, wrapping.
  - The header is written on the first FILL cycle without consuming a log_dv_in slot; a sample arriving in that same cycle is still accepted into word 1.
- Disabled: all words are samples; no sequence counter exists.

Decomposition:
- Package log_pkg:
  - state encoding (IDLE, FILL, READY, DRAIN);
  - header magic 4'hA;
  - default widths W_OUT and DEPTH_LOG2.
- One sub-module: log_buf_ram (parametrised simple dual-port RAM with registered read).
- FSM, decimation, and drop logic stay in the top module.

Test Plan:
- DEPTH_LOG2=4, mask=8'b0000_0001, dec=0, cont=0, arm, 16 valid samples on chan 0 with data=i<<2 -> block_rdy_out=1; reading 16 times returns i (top 16 of 18 bits); then IDLE, busy_out=0.
- mask=8'b0000_0110, dec=3, interleaved chan 1/2 samples, 12 each -> 8 stored words: 4 per channel, at sample indices 0,3,6,9, order preserved; chan 0 samples ignored.
- Block full (READY), 5 more masked samples -> drop_cnt_out=5; W_DROP=3 with 10 drops -> saturates at 7.
- Mid-FILL after 7 words, assert rst_in for one cycle -> all outputs 0, IDLE; a subsequent rd_in leaves data_out=0.
- cont=1, two back-to-back blocks -> after the 16th read of block 0, FILL resumes; block 1 data correct; with LOG_BLOCK_HEADER_EN, word 0 reads 16'hA000 then 16'hA001.
- abort_in during DRAIN at word 5 -> block_rdy_out=0 next cycle, IDLE; a new arm plus a full block reads from word 0.
